// File: rtl/ks_arith_pkg.sv
// Shared helpers for the Kogge-Stone arithmetic blocks: prefix depth
// calculation and the per-bit generate/propagate pair.
package ks_arith_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } pg_bit_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r++;
    return r;
  endfunction

  function automatic int unsigned num_steps(input int unsigned precision);
    return clog2(precision);
  endfunction

  function automatic int unsigned latency(input int unsigned precision);
    return num_steps(precision) + 1;
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: g/p combine at distance SPAN followed by
// its pipeline register, with a pass-through side payload.
module ks_prefix_level
  import ks_arith_pkg::*;
#(
  parameter int unsigned PRECISION = 8,
  parameter int unsigned SPAN      = 1,
  parameter int unsigned SIDE_W    = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    valid_i,
  input  pg_bit_t [PRECISION-1:0] pg_i,
  input  logic [SIDE_W-1:0]       side_i,
  output logic                    valid_o,
  output pg_bit_t [PRECISION-1:0] pg_o,
  output logic [SIDE_W-1:0]       side_o
);

  pg_bit_t [PRECISION-1:0] pg_comb;

  for (genvar i = 0; i < PRECISION; i++) begin : g_bit
    if (i >= SPAN) begin : g_comb
      assign pg_comb[i].g = pg_i[i].g | (pg_i[i].p & pg_i[i-SPAN].g);
      assign pg_comb[i].p = pg_i[i].p & pg_i[i-SPAN].p;
    end else begin : g_pass
      assign pg_comb[i] = pg_i[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      pg_o    <= '0;
      side_o  <= '0;
    end else if (en_i) begin
      valid_o <= valid_i;
      if (valid_i) begin
        pg_o   <= pg_comb;
        side_o <= side_i;
      end
    end
  end

endmodule

// File: rtl/kogge_stone_subtractor_pipe.sv
// Pipelined, flow-controlled Kogge-Stone subtractor: a - b computed as
// a + ~b + 1, one register bank per prefix level, global-stall handshake.
module kogge_stone_subtractor_pipe
  import ks_arith_pkg::*;
#(
  parameter int unsigned PRECISION = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [PRECISION-1:0] operand_a_i,
  input  logic [PRECISION-1:0] operand_b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PRECISION-1:0] result_o,
  output logic                 borrow_o,
  output logic                 overflow_o
);

  localparam int unsigned NUM_STEPS = num_steps(PRECISION);
  localparam int unsigned SIDE_W    = PRECISION + 2;

  logic                    advance;
  logic [PRECISION-1:0]    b_inv;
  logic [PRECISION-1:0]    p_raw;
  pg_bit_t [PRECISION-1:0] pg_in;

  logic                    valid_s0;
  pg_bit_t [PRECISION-1:0] pg_s0;
  logic [SIDE_W-1:0]       side_s0;

  logic [NUM_STEPS:0]      valid_s;
  pg_bit_t [PRECISION-1:0] pg_s   [NUM_STEPS+1];
  logic [SIDE_W-1:0]       side_s [NUM_STEPS+1];

  assign b_inv = ~operand_b_i;

  // Carry-in of 1 is folded into bit 0's generate.
  for (genvar i = 0; i < PRECISION; i++) begin : g_pg
    if (i == 0) begin : g_lsb
      assign pg_in[i].g = operand_a_i[i] | b_inv[i];
    end else begin : g_upper
      assign pg_in[i].g = operand_a_i[i] & b_inv[i];
    end
    assign pg_in[i].p = operand_a_i[i] ^ b_inv[i];
    assign p_raw[i]   = pg_in[i].p;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_s0 <= 1'b0;
      pg_s0    <= '0;
      side_s0  <= '0;
    end else if (advance) begin
      valid_s0 <= valid_i;
      if (valid_i) begin
        pg_s0   <= pg_in;
        side_s0 <= {p_raw, operand_a_i[PRECISION-1], operand_b_i[PRECISION-1]};
      end
    end
  end

  assign valid_s[0] = valid_s0;
  assign pg_s[0]    = pg_s0;
  assign side_s[0]  = side_s0;

  for (genvar k = 0; k < NUM_STEPS; k++) begin : g_level
    ks_prefix_level #(
      .PRECISION (PRECISION),
      .SPAN      (32'd1 << k),
      .SIDE_W    (SIDE_W)
    ) u_level (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (advance),
      .valid_i (valid_s[k]),
      .pg_i    (pg_s[k]),
      .side_i  (side_s[k]),
      .valid_o (valid_s[k+1]),
      .pg_o    (pg_s[k+1]),
      .side_o  (side_s[k+1])
    );
  end

  assign valid_o = valid_s[NUM_STEPS];
  assign advance = !valid_o || ready_i;
  assign ready_o = advance;

  pg_bit_t [PRECISION-1:0] pg_last;
  logic [SIDE_W-1:0]       side_last;
  logic [PRECISION-1:0]    carry;
  logic [PRECISION-1:0]    group_p_unused;
  logic [PRECISION-1:0]    p_raw_q;
  logic [PRECISION-1:0]    sum;
  logic                    a_msb_q;
  logic                    b_msb_q;

  assign pg_last   = pg_s[NUM_STEPS];
  assign side_last = side_s[NUM_STEPS];
  assign p_raw_q   = side_last[SIDE_W-1:2];
  assign a_msb_q   = side_last[1];
  assign b_msb_q   = side_last[0];

  for (genvar i = 0; i < PRECISION; i++) begin : g_carry
    assign carry[i]          = pg_last[i].g;
    assign group_p_unused[i] = pg_last[i].p;
  end

  assign sum = {p_raw_q[PRECISION-1:1] ^ carry[PRECISION-2:0], ~p_raw_q[0]};

  // Outputs derive only from the final register bank; masking with valid_o
  // gives the all-zero reset value without a second output register.
  always_comb begin
    result_o   = '0;
    borrow_o   = 1'b0;
    overflow_o = 1'b0;
    if (valid_o) begin
      result_o   = sum;
      borrow_o   = ~carry[PRECISION-1];
      overflow_o = (a_msb_q ^ b_msb_q) & (a_msb_q ^ sum[PRECISION-1]);
    end
  end

endmodule

// File: tb/tb_kogge_stone_subtractor_pipe.sv
// Scoreboard bench for kogge_stone_subtractor_pipe with directed vectors.
module tb_kogge_stone_subtractor_pipe;

  typedef struct {
    logic [7:0] r;
    logic       bo;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       bo;
    logic       ov;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] result_o;
  logic       borrow_o;
  logic       overflow_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n_out = 0;
  int unsigned cur_run = 0;
  int unsigned last_run = 0;
  int unsigned total_waits = 0;
  exp_t        sb[$];
  exp_t        mon_e;

  vec_t stream_vecs[16] = '{
    '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0},
    '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0},
    '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0},
    '{8'h20, 8'h10, 8'h10, 1'b0, 1'b0},
    '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1},
    '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1},
    '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1},
    '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b1},
    '{8'hC8, 8'h64, 8'h64, 1'b0, 1'b1},
    '{8'h64, 8'hC8, 8'h9C, 1'b1, 1'b1},
    '{8'h12, 8'h34, 8'hDE, 1'b1, 1'b0},
    '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0},
    '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0},
    '{8'h01, 8'h00, 8'h01, 1'b0, 1'b0},
    '{8'h90, 8'hA0, 8'hF0, 1'b1, 1'b0},
    '{8'h3C, 8'h0F, 8'h2D, 1'b0, 1'b0}
  };

  kogge_stone_subtractor_pipe #(.PRECISION(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .operand_a_i (operand_a),
    .operand_b_i (operand_b),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .borrow_o    (borrow_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] r,
                      input logic bo, input logic ov);
    int unsigned waits;
    exp_t e;
    waits = 0;
    @(negedge clk);
    operand_a = a;
    operand_b = b;
    valid_i   = 1'b1;
    while (!ready_o && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ready_o %0b after %0d cycles", ready_o, waits);
      valid_i = 1'b0;
    end else begin
      total_waits += waits;
      e.r  = r;
      e.bo = bo;
      e.ov = ov;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0;
    end
  endtask

  // Call right after send() returns on the acceptance edge.
  task automatic measure_latency(input string name);
    int unsigned edges;
    bit seen;
    edges = 1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid_i = 1'b0;
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    check(name, seen ? edges : 32'd0, 32'd4);
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_ni && valid_o && ready_i) begin
      cur_run++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h/%0b/%0b expected none", result_o, borrow_o, overflow_o);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("out%0d", n_out), {23'd0, result_o, borrow_o, overflow_o},
              {23'd0, mon_e.r, mon_e.bo, mon_e.ov});
      end
      n_out++;
    end else if (cur_run != 0) begin
      last_run = cur_run;
      cur_run  = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni    = 1'b1;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    operand_a = '0;
    operand_b = '0;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_borrow", borrow_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_ready", ready_o, 1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", ready_o, 1);

    send(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    measure_latency("latency_first");
    idle(4);

    send(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    send(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    send(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    send(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    idle(8);

    total_waits = 0;
    for (int i = 0; i < 16; i++)
      send(stream_vecs[i].a, stream_vecs[i].b, stream_vecs[i].r, stream_vecs[i].bo, stream_vecs[i].ov);
    idle(8);
    check("stream_ready", total_waits, 0);
    check("stream_run", last_run, 16);

    ready_i = 1'b0;
    send(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    send(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    send(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    @(negedge clk);
    valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_ready", ready_o, 0);
      check("stall_valid", valid_o, 1);
      check("stall_out", {22'd0, result_o, borrow_o, overflow_o}, {22'd0, 8'h02, 1'b0, 1'b0});
      if (c >= 1 && c <= 3) begin
        operand_a = 8'hEE;
        operand_b = 8'h11;
        valid_i   = 1'b1;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    idle(8);
    check("drain_run", last_run, 4);

    send(8'h11, 8'h01, 8'h10, 1'b0, 1'b0);
    send(8'h22, 8'h02, 8'h20, 1'b0, 1'b0);
    send(8'h33, 8'h03, 8'h30, 1'b0, 1'b0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_ni  = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", valid_o, 0);
    check("midrst_result", result_o, 0);
    check("midrst_ready", ready_o, 1);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("post_rst_idle", valid_o, 0);
    end
    send(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    measure_latency("latency_after_rst");
    idle(8);

    check("sb_empty", sb.size(), 0);
    check("out_count", n_out, 26);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
